// File: rtl/ntt_pkg.sv
// Shared types and modular helpers for the streaming NTT core.
package ntt_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOAD,
        ST_COMPUTE,
        ST_SCALE,
        ST_UNLOAD
    } state_t;

    function automatic logic [31:0] bitrev(input logic [31:0] i, input int logn);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < logn; k++) r[logn-1-k] = i[k];
        return r;
    endfunction

    // Operands are already in [0, q), so one conditional correction suffices.
    function automatic logic [31:0] mod_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] q);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, q}) s = s - {1'b0, q};
        return s[31:0];
    endfunction

    function automatic logic [31:0] mod_sub(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] q);
        return (a >= b) ? (a - b) : (a + q - b);
    endfunction

endpackage

// File: rtl/ntt_stream_core_if.sv
// Coefficient stream in/out bundle for ntt_stream_core.
interface ntt_stream_if #(parameter int W = 5);
    logic         mode;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         out_ready;

    modport slave (
        input  mode, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output mode, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/ntt_stream_core_butterfly.sv
// Registered mod-Q multiply followed by combinational mod add/sub (1-cycle latency).
module ntt_butterfly
    import ntt_pkg::*;
#(
    parameter int Q = 17,
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] w,
    output logic [W-1:0] t,
    output logic [W-1:0] sum,
    output logic [W-1:0] diff
);
    localparam int P = 2 * W;

    logic [W-1:0] a_r, t_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_r <= '0;
            t_r <= '0;
        end else begin
            a_r <= a;
            t_r <= W'((P'(b) * P'(w)) % P'(Q));
        end
    end

    assign t    = t_r;
    assign sum  = W'(mod_add(32'(a_r), 32'(t_r), 32'(Q)));
    assign diff = W'(mod_sub(32'(a_r), 32'(t_r), 32'(Q)));
endmodule

// File: rtl/ntt_stream_core.sv
// Iterative radix-2 DIT NTT: streamed bit-reversed load, one butterfly/cycle, natural unload.
// Optional inverse transform enabled by defining NTT_STREAM_INVERSE_EN.
module ntt_stream_core
    import ntt_pkg::*;
#(
    parameter int Q         = 17,
    parameter int N         = 8,
    parameter int OMEGA     = 2,
    parameter int OMEGA_INV = 9,
    parameter int N_INV     = 15,
    parameter int W         = $clog2(Q),
    parameter int LOGN      = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    ntt_stream_if.slave  s,
    output logic         busy
);
    localparam int CW = LOGN + 1;

    state_t state, state_n;

    logic [N-1:0][W-1:0]   mem;
    logic [N/2-1:0][W-1:0] tw;
    logic [CW-1:0]         cnt;
    logic [LOGN-1:0]       stg;
    logic [LOGN-2:0]       bfi;
    logic                  drain;
    logic                  mode_r;
    logic                  wb_vld;
    logic [LOGN-1:0]       wb_lo, wb_hi;

    logic [W-1:0] bf_a, bf_b, bf_w, bf_t, bf_sum, bf_diff;
    logic [W-1:0] rd_lo, rd_hi, in_red;
    logic [LOGN-1:0] lo, hi;
    logic [LOGN-2:0] tw_idx;
    logic in_ready_c, out_valid_c, in_hs, out_hs;

`ifdef NTT_STREAM_INVERSE_EN
    logic [N/2-1:0][W-1:0] twi;
    logic [W-1:0] bfi_t, bfi_b;
    logic [W-1:0] bfi_sum, bfi_diff;
    logic inv_sel;
    assign inv_sel = mode_r;
`endif

    ntt_butterfly #(.Q(Q), .W(W)) u_bf (
        .clk(clk), .reset(reset), .a(bf_a), .b(bf_b), .w(bf_w),
        .t(bf_t), .sum(bf_sum), .diff(bf_diff)
    );

`ifdef NTT_STREAM_INVERSE_EN
    // Second multiplier only grows the inverse twiddle table during INIT.
    assign bfi_b = (cnt == '0) ? W'(1) : bfi_t;
    ntt_butterfly #(.Q(Q), .W(W)) u_bf_inv (
        .clk(clk), .reset(reset), .a('0), .b(bfi_b), .w(W'(OMEGA_INV)),
        .t(bfi_t), .sum(bfi_sum), .diff(bfi_diff)
    );
`endif

    assign in_ready_c  = (state == ST_IDLE) || (state == ST_LOAD);
    assign out_valid_c = (state == ST_UNLOAD);
    assign in_hs       = in_ready_c & s.in_valid;
    assign out_hs      = out_valid_c & s.out_ready;
    assign in_red      = (s.in_data >= W'(Q)) ? (s.in_data - W'(Q)) : s.in_data;

    assign s.in_ready  = in_ready_c;
    assign s.out_valid = out_valid_c;
    assign s.out_data  = out_valid_c ? mem[cnt[LOGN-1:0]] : '0;
    assign s.out_last  = out_valid_c && (cnt == CW'(N-1));
    assign busy        = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= ST_INIT;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_INIT:    if (cnt == CW'(N/2-1)) state_n = ST_IDLE;
            ST_IDLE:    if (in_hs) state_n = ST_LOAD;
            ST_LOAD:    if (in_hs && cnt == CW'(N-1)) state_n = ST_COMPUTE;
            ST_COMPUTE: if (drain && cnt == CW'(1)) begin
`ifdef NTT_STREAM_INVERSE_EN
                state_n = inv_sel ? ST_SCALE : ST_UNLOAD;
`else
                state_n = ST_UNLOAD;
`endif
            end
            ST_SCALE:   if (cnt == CW'(N-1)) state_n = ST_UNLOAD;
            ST_UNLOAD:  if (out_hs && cnt == CW'(N-1)) state_n = ST_IDLE;
            default:    state_n = ST_INIT;
        endcase
    end

    // Pair addressing for butterfly bfi of stage stg.
    always_comb begin
        logic [31:0] j, l;
        j      = 32'(bfi) & ((32'd1 << stg) - 32'd1);
        l      = ((32'(bfi) >> stg) << (stg + 1)) | j;
        lo     = LOGN'(l);
        hi     = LOGN'(l | (32'd1 << stg));
        tw_idx = (LOGN-1)'(j << (LOGN - 1 - int'(stg)));
    end

    // The previous butterfly's results are still in flight; forward them.
    always_comb begin
        rd_lo = mem[lo];
        rd_hi = mem[hi];
        if (wb_vld && wb_lo == lo)      rd_lo = bf_sum;
        else if (wb_vld && wb_hi == lo) rd_lo = bf_diff;
        if (wb_vld && wb_lo == hi)      rd_hi = bf_sum;
        else if (wb_vld && wb_hi == hi) rd_hi = bf_diff;
    end

    always_comb begin
        bf_a = '0;
        bf_b = '0;
        bf_w = '0;
        case (state)
            ST_INIT: begin
                bf_b = (cnt == '0) ? W'(1) : bf_t;
                bf_w = W'(OMEGA);
            end
            ST_COMPUTE: begin
                if (!drain) begin
                    bf_a = rd_lo;
                    bf_b = rd_hi;
                    bf_w = tw[tw_idx];
`ifdef NTT_STREAM_INVERSE_EN
                    if (inv_sel) bf_w = twi[tw_idx];
                end else begin
                    // Prime the scale pipe so SCALE writes one coefficient per cycle.
                    bf_b = mem[0];
                    bf_w = W'(N_INV);
`endif
                end
            end
`ifdef NTT_STREAM_INVERSE_EN
            ST_SCALE: begin
                bf_b = mem[LOGN'(cnt + CW'(1))];
                bf_w = W'(N_INV);
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            stg    <= '0;
            bfi    <= '0;
            drain  <= 1'b0;
            mode_r <= 1'b0;
            wb_vld <= 1'b0;
            wb_lo  <= '0;
            wb_hi  <= '0;
        end else begin
            wb_vld <= 1'b0;
            if (wb_vld) begin
                mem[wb_lo] <= bf_sum;
                mem[wb_hi] <= bf_diff;
            end
            case (state)
                ST_INIT: begin
                    tw[cnt[LOGN-2:0]] <= (cnt == '0) ? W'(1) : bf_t;
`ifdef NTT_STREAM_INVERSE_EN
                    twi[cnt[LOGN-2:0]] <= bfi_b;
`endif
                    cnt <= (cnt == CW'(N/2-1)) ? '0 : cnt + CW'(1);
                end
                ST_IDLE: begin
                    stg   <= '0;
                    bfi   <= '0;
                    drain <= 1'b0;
                    if (in_hs) begin
                        mem[0] <= in_red;
                        mode_r <= s.mode;
                        cnt    <= CW'(1);
                    end
                end
                ST_LOAD: if (in_hs) begin
                    mem[LOGN'(bitrev(32'(cnt), LOGN))] <= in_red;
                    cnt <= (cnt == CW'(N-1)) ? '0 : cnt + CW'(1);
                end
                ST_COMPUTE: begin
                    if (!drain) begin
                        wb_vld <= 1'b1;
                        wb_lo  <= lo;
                        wb_hi  <= hi;
                        if (bfi == (LOGN-1)'(N/2-1)) begin
                            bfi <= '0;
                            if (stg == LOGN'(LOGN-1)) drain <= 1'b1;
                            else                      stg   <= stg + LOGN'(1);
                        end else begin
                            bfi <= bfi + (LOGN-1)'(1);
                        end
                    end else if (cnt == CW'(1)) begin
                        cnt   <= '0;
                        drain <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_SCALE: begin
                    mem[cnt[LOGN-1:0]] <= bf_t;
                    cnt <= (cnt == CW'(N-1)) ? '0 : cnt + CW'(1);
                end
                ST_UNLOAD: if (out_hs) cnt <= (cnt == CW'(N-1)) ? '0 : cnt + CW'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ntt_stream_core.sv
// Directed-vector bench for ntt_stream_core (Q=17, N=8, OMEGA=2).
module tb_ntt_stream_core;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy;
    int checks = 0;
    int failures = 0;
    logic [4:0] vin [8];
    logic [4:0] vexp [8];

    ntt_stream_if #(.W(5)) bus ();

    ntt_stream_core #(.Q(17), .N(8), .OMEGA(2), .OMEGA_INV(9), .N_INV(15)) dut (
        .clk(clk), .reset(reset), .s(bus), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic test_reset(input string name);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 ||
            bus.out_data !== 5'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s reset_state: rdy=%b vld=%b last=%b data=%0d busy=%b want 0 0 0 0 1",
                     name, bus.in_ready, bus.out_valid, bus.out_last, bus.out_data, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL %s init_cycle%0d: rdy=%b busy=%b want 0 1", name, i, bus.in_ready, busy);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s idle_after_init: rdy=%b busy=%b vld=%b want 1 0 0",
                     name, bus.in_ready, busy, bus.out_valid);
        end
        @(negedge clk);
    endtask

    task automatic send_vec(input string name);
        int w = 0;
        while (bus.in_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = vin[i];
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL %s load_ready%0d: got %b want 1", name, i, bus.in_ready);
            end
            @(negedge clk);
        end
        // Garbage beats outside IDLE/LOAD must be ignored.
        bus.in_data = 5'd7;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s compute_ready: rdy=%b busy=%b want 0 1", name, bus.in_ready, busy);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic recv_vec(input string name, input bit toggle);
        int k = 0;
        int cyc = 0;
        bit hold_chk = 1'b0;
        logic [4:0] held = '0;
        while (k < 8 && cyc < 300) begin
            bus.out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (hold_chk) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== held) begin
                    failures++;
                    $display("FAIL %s hold_beat%0d: vld=%b data=%0d want 1 %0d",
                             name, k, bus.out_valid, bus.out_data, held);
                end
            end
            hold_chk = 1'b0;
            if (bus.out_valid === 1'b1) begin
                if (bus.out_ready) begin
                    checks++;
                    if (bus.out_data !== vexp[k] || bus.out_last !== (k == 7)) begin
                        failures++;
                        $display("FAIL %s beat%0d: data=%0d last=%b want %0d %b",
                                 name, k, bus.out_data, bus.out_last, vexp[k], (k == 7));
                    end
                    k++;
                end else begin
                    held = bus.out_data;
                    hold_chk = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (k != 8) begin
            failures++;
            $display("FAIL %s timeout: got %0d beats want 8", name, k);
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s post_unload: vld=%b busy=%b want 0 0", name, bus.out_valid, busy);
        end
        @(negedge clk);
    endtask

    task automatic test_delta0();
        vin  = '{5'd1, 5'd0, 5'd17, 5'd0, 5'd0, 5'd17, 5'd0, 5'd0};
        vexp = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1};
        send_vec("delta0");
        recv_vec("delta0", 1'b0);
    endtask

    task automatic test_delta1();
        vin  = '{5'd0, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        vexp = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16, 5'd15, 5'd13, 5'd9};
        send_vec("delta1");
        recv_vec("delta1", 1'b0);
    endtask

    task automatic test_ones();
        vin  = '{5'd1, 5'd18, 5'd1, 5'd18, 5'd1, 5'd1, 5'd1, 5'd1};
        vexp = '{5'd8, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        send_vec("ones");
        recv_vec("ones", 1'b0);
    endtask

    task automatic test_backpressure();
        vin  = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1};
        vexp = '{5'd8, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        send_vec("bp");
        recv_vec("bp", 1'b1);
    endtask

`ifdef NTT_STREAM_INVERSE_EN
    task automatic test_inverse();
        bus.mode = 1'b1;
        vin  = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16, 5'd15, 5'd13, 5'd9};
        vexp = '{5'd0, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        send_vec("inverse");
        bus.mode = 1'b0;
        recv_vec("inverse", 1'b0);
    endtask
`endif

    task automatic test_reset_mid_compute();
        vin = '{5'd3, 5'd5, 5'd7, 5'd9, 5'd11, 5'd13, 5'd15, 5'd2};
        send_vec("abort");
        repeat (3) @(negedge clk);
        test_reset("abort");
        vin  = '{5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        vexp = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1};
        send_vec("after_abort");
        recv_vec("after_abort", 1'b0);
    endtask

    initial begin
        bus.mode      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        test_reset("por");
        test_delta0();
        test_delta1();
        test_ones();
        test_backpressure();
`ifdef NTT_STREAM_INVERSE_EN
        test_inverse();
`endif
        test_reset_mid_compute();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
